// File: rtl/snake_segment_scanner_if.sv
// Segment-position bus between the game-tick side, snakeMoveLogic and the segment scanner.
// The scanner uses the slave modport; the driving side uses master.
interface snake_segment_scanner_if #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned COORD_W = 20
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic               tick;
  logic [LEN_W-1:0]   length;
  logic               wallsOn;
  logic [COORD_W-1:0] X;
  logic [COORD_W-1:0] Y;
  logic [COORD_W-1:0] foodX;
  logic [COORD_W-1:0] foodY;
  logic [19:0]        bitNum;
  logic               scanBusy;
  logic               scanDone;
  logic               ateFood;
  logic               gameOver;

  modport master (
    output tick, length, wallsOn, X, Y, foodX, foodY,
    input  bitNum, scanBusy, scanDone, ateFood, gameOver
  );

  modport slave (
    input  tick, length, wallsOn, X, Y, foodX, foodY,
    output bitNum, scanBusy, scanDone, ateFood, gameOver
  );
endinterface

// File: rtl/snake_segment_scanner.sv
// Per-tick walk over the snake segments: latches the head, checks walls and self-collision,
// and reports scan completion, food pickup and a sticky game-over flag.
module snake_segment_scanner #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned COORD_W = 20,
  parameter int unsigned X_MIN   = 0,
  parameter int unsigned X_MAX   = 639,
  parameter int unsigned Y_MIN   = 0,
  parameter int unsigned Y_MAX   = 479
) (
  input logic                    clock,
  input logic                    reset,
  snake_segment_scanner_if.slave bus
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned BIT_W = 20;

  typedef enum logic [2:0] {StIdle, StIssue, StSample, StDone, StOver} state_e;

  state_e             stateQ, stateD;
  logic [LEN_W-1:0]   idxQ, idxD;
  logic [LEN_W-1:0]   lenQ, lenD;
  logic               wallsQ, wallsD;
  logic [COORD_W-1:0] headXQ, headXD;
  logic [COORD_W-1:0] headYQ, headYD;

  logic [BIT_W-1:0]   bitNumD;
  logic               busyD, doneD, ateD, overD;

  logic [LEN_W-1:0]   lenClamp;
  logic               xLow, xHigh, yLow, yHigh, outside, hit;

  always_comb begin
    if (bus.length == '0) begin
      lenClamp = LEN_W'(1);
    end else if (bus.length > LEN_W'(MAX_LEN)) begin
      lenClamp = LEN_W'(MAX_LEN);
    end else begin
      lenClamp = bus.length;
    end
  end

  // A zero lower bound can never be violated by an unsigned coordinate.
  if (X_MIN > 0) begin : gXLow
    assign xLow = bus.X < COORD_W'(X_MIN);
  end else begin : gXNoLow
    assign xLow = 1'b0;
  end

  if (Y_MIN > 0) begin : gYLow
    assign yLow = bus.Y < COORD_W'(Y_MIN);
  end else begin : gYNoLow
    assign yLow = 1'b0;
  end

  assign xHigh   = bus.X > COORD_W'(X_MAX);
  assign yHigh   = bus.Y > COORD_W'(Y_MAX);
  assign outside = xLow | xHigh | yLow | yHigh;
  assign hit     = (idxQ == '0) ? (wallsQ & outside)
                                : ((bus.X == headXQ) && (bus.Y == headYQ));

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ       <= StIdle;
      idxQ         <= '0;
      lenQ         <= LEN_W'(1);
      wallsQ       <= 1'b0;
      headXQ       <= '0;
      headYQ       <= '0;
      bus.bitNum   <= '0;
      bus.scanBusy <= 1'b0;
      bus.scanDone <= 1'b0;
      bus.ateFood  <= 1'b0;
      bus.gameOver <= 1'b0;
    end else begin
      stateQ       <= stateD;
      idxQ         <= idxD;
      lenQ         <= lenD;
      wallsQ       <= wallsD;
      headXQ       <= headXD;
      headYQ       <= headYD;
      bus.bitNum   <= bitNumD;
      bus.scanBusy <= busyD;
      bus.scanDone <= doneD;
      bus.ateFood  <= ateD;
      bus.gameOver <= overD;
    end
  end

  always_comb begin
    stateD = stateQ;
    idxD   = idxQ;
    lenD   = lenQ;
    wallsD = wallsQ;
    headXD = headXQ;
    headYD = headYQ;
    case (stateQ)
      StIdle: begin
        if (bus.tick) begin
          stateD = StIssue;
          idxD   = '0;
          lenD   = lenClamp;
          wallsD = bus.wallsOn;
        end
      end
      StIssue: stateD = StSample;
      StSample: begin
        if (idxQ == '0) begin
          headXD = bus.X;
          headYD = bus.Y;
        end
        if (hit) begin
          stateD = StOver;
        end else if (idxQ == lenQ - LEN_W'(1)) begin
          stateD = StDone;
        end else begin
          idxD   = idxQ + LEN_W'(1);
          stateD = StIssue;
        end
      end
      StDone: begin
        stateD = StIdle;
        idxD   = '0;
      end
      StOver:  stateD = StOver;
      default: stateD = StIdle;
    endcase
  end

  // Next values of the output registers, decoded from the next state so outputs line up with it.
  always_comb begin
    bitNumD = (stateD == StOver) ? '0 : BIT_W'(idxD);
    busyD   = (stateD == StIssue) || (stateD == StSample) || (stateD == StDone);
    doneD   = (stateD == StDone);
    ateD    = doneD && (headXD == bus.foodX) && (headYD == bus.foodY);
    overD   = (stateD == StOver);
  end
endmodule

// File: tb/tb_snake_segment_scanner.sv
// Directed bench for snake_segment_scanner: a scoreboard queue of expected scan outcomes
// checked by an independent monitor, plus direct checks on reset and the bitNum walk.
module tb_snake_segment_scanner;
  typedef struct {
    bit over;
    bit ate;
    int lat;
  } exp_t;

  logic clock;
  logic reset;
  int   cyc;
  int   tickAt;
  int   nVec;
  int   nMis;
  bit   overSeen;
  exp_t sb[$];
  logic [19:0] segX [32];
  logic [19:0] segY [32];

  snake_segment_scanner_if #(.MAX_LEN(16), .COORD_W(20)) bus ();

  snake_segment_scanner #(
    .MAX_LEN(16), .COORD_W(20), .X_MIN(0), .X_MAX(639), .Y_MIN(0), .Y_MAX(479)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Stand-in for snakeMoveLogic: position lookup by segment index.
  always_comb begin
    bus.X = segX[bus.bitNum[4:0]];
    bus.Y = segY[bus.bitNum[4:0]];
  end

  task automatic chk(input string name, input longint act, input longint req);
    nVec++;
    if (act !== req) begin
      nMis++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      overSeen = 1'b0;
    end else begin
      chk("ateFood_without_scanDone", bus.ateFood & ~bus.scanDone, 0);
      if (bus.scanDone || (bus.gameOver && !overSeen)) begin
        if (sb.size() == 0) begin
          nVec++;
          nMis++;
          $display("FAIL unexpected_event: got scanDone=%b gameOver=%b, required none (t=%0t)",
                   bus.scanDone, bus.gameOver, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("event_gameOver", bus.gameOver, e.over);
          chk("event_ateFood", bus.ateFood, e.ate);
          chk("event_latency", cyc - tickAt, e.lat);
        end
      end
      if (bus.gameOver) overSeen = 1'b1;
    end
  end

  task automatic setSeg(input int i, input int x, input int y);
    segX[i] = 20'(x);
    segY[i] = 20'(y);
  endtask

  task automatic pulseTick(input bit record);
    @(negedge clock);
    bus.tick = 1'b1;
    if (record) tickAt = cyc;
    @(negedge clock);
    bus.tick = 1'b0;
  endtask

  // Returns at the negedge of cycle 1 (first ISSUE cycle) of the scan.
  task automatic startScan(input int len, input bit walls, input bit over, input bit ate,
                           input int lat);
    bus.length  = 5'(len);
    bus.wallsOn = walls;
    sb.push_back('{over: over, ate: ate, lat: lat});
    pulseTick(1'b1);
  endtask

  task automatic pulseReset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    nVec = 0;
    nMis = 0;
    tickAt = 0;
    overSeen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      segX[i] = 20'(1000 + i);
      segY[i] = 20'd300;
    end
    bus.tick    = 1'b0;
    bus.length  = 5'd1;
    bus.wallsOn = 1'b0;
    bus.foodX   = 20'd1000;
    bus.foodY   = 20'd1000;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_bitNum", bus.bitNum, 0);
    chk("reset_scanBusy", bus.scanBusy, 0);
    chk("reset_scanDone", bus.scanDone, 0);
    chk("reset_gameOver", bus.gameOver, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Three-segment walk; food sits on a body segment, not the head.
    setSeg(0, 368, 200); setSeg(1, 367, 200); setSeg(2, 366, 200);
    bus.foodX = 20'd367; bus.foodY = 20'd200;
    startScan(3, 1'b0, 1'b0, 1'b0, 7);
    for (int k = 1; k <= 6; k++) begin
      chk("t1_bitNum", bus.bitNum, (k - 1) / 2);
      chk("t1_scanBusy", bus.scanBusy, 1);
      @(negedge clock);
    end
    repeat (3) @(negedge clock);
    chk("t1_gameOver", bus.gameOver, 0);

    // Single segment eating food.
    setSeg(0, 10, 20);
    bus.foodX = 20'd10; bus.foodY = 20'd20;
    startScan(1, 1'b0, 1'b0, 1'b1, 3);
    repeat (4) @(negedge clock);
    bus.foodX = 20'd1000; bus.foodY = 20'd1000;

    // Out-of-bounds head with walls disabled is harmless.
    setSeg(0, 640, 100);
    startScan(1, 1'b0, 1'b0, 1'b0, 3);
    repeat (4) @(negedge clock);

    // Head exactly on the max bounds with walls enabled is legal.
    setSeg(0, 639, 479); setSeg(1, 638, 479);
    startScan(2, 1'b1, 1'b0, 1'b0, 5);
    repeat (6) @(negedge clock);

    // length=0 scans one segment; a tick while busy is dropped.
    setSeg(0, 5, 5);
    startScan(0, 1'b0, 1'b0, 1'b0, 3);
    bus.tick = 1'b1;
    @(negedge clock);
    bus.tick = 1'b0;
    repeat (8) @(negedge clock);
    chk("t6_busy_after_dropped_tick", bus.scanBusy, 0);

    // length=20 clamps to 16; mid-scan length change ignored; tick during DONE dropped.
    for (int i = 0; i < 16; i++) setSeg(i, 100 + i, 50);
    startScan(20, 1'b0, 1'b0, 1'b0, 33);
    bus.length = 5'd1;
    repeat (32) @(negedge clock);
    chk("t6_scanDone_at_33", bus.scanDone, 1);
    bus.tick = 1'b1;
    @(negedge clock);
    bus.tick = 1'b0;
    repeat (6) @(negedge clock);
    chk("t6_busy_after_done_tick", bus.scanBusy, 0);

    // Reset in the middle of a five-segment scan.
    for (int i = 0; i < 5; i++) setSeg(i, 200 + i, 60);
    bus.length = 5'd5;
    pulseTick(1'b0);
    repeat (4) @(negedge clock);
    chk("t5_bitNum_before_reset", bus.bitNum, 2);
    reset = 1'b1;
    #1;
    chk("t5_async_bitNum", bus.bitNum, 0);
    chk("t5_async_scanBusy", bus.scanBusy, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    startScan(5, 1'b0, 1'b0, 1'b0, 11);
    repeat (12) @(negedge clock);

    // Wall hit on the head.
    setSeg(0, 640, 100); setSeg(1, 639, 100); setSeg(2, 638, 100);
    startScan(3, 1'b1, 1'b1, 1'b0, 3);
    repeat (4) @(negedge clock);
    chk("t3_gameOver", bus.gameOver, 1);
    chk("t3_bitNum_over", bus.bitNum, 0);
    pulseReset();
    @(negedge clock);
    chk("t3_gameOver_cleared", bus.gameOver, 0);

    // Self-collision on the last body segment; gameOver then sticks through ticks.
    setSeg(0, 368, 200); setSeg(1, 367, 200); setSeg(2, 367, 201); setSeg(3, 368, 200);
    startScan(4, 1'b0, 1'b1, 1'b0, 9);
    repeat (10) @(negedge clock);
    chk("t2_gameOver", bus.gameOver, 1);
    chk("t2_scanBusy", bus.scanBusy, 0);
    pulseTick(1'b0);
    repeat (12) @(negedge clock);
    chk("t2_gameOver_sticky", bus.gameOver, 1);
    chk("t2_scanBusy_sticky", bus.scanBusy, 0);
    chk("t2_bitNum_sticky", bus.bitNum, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
